mips_instr_encoder: RTL
=======================

Name: mips_instr_encoder

Overview:
- Encodes mnemonic-level instruction requests into 32-bit MIPS words and writes them sequentially into instruction memory.
- Serves as the program loader / self-test generator in front of the IM, and is the inverse of the Ctrl/ALUCtrl decode path.
- Covers the same instruction set the core decodes: R-type ALU/shift ops, JR, ADDI/ADDIU/ANDI/ORI/XORI/LUI/SLTI/SLTIU, LW/SW, BEQ/BNE, J/JAL.
- Computes branch offsets and jump targets from absolute byte addresses.

Parameters:
- RESET_PC, 32'h0000_3000: write address after reset.
- COUNT_W, 16: width of the written-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- base_load  in  1  loads base_addr into the write pointer; honoured in IDLE only.
- base_addr  in  32  new write pointer; bits [1:0] are forced to 0.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_mnem  in  5  mnemonic code (ENC_MN_*); 31 is illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate for I-type ops.
- in_target  in  32  absolute byte address for BEQ/BNE/J/JAL.
- im_we  out  1  IM write strobe, held until im_ready.
- im_addr  out  32  IM byte address (word aligned).
- im_wdata  out  32  encoded instruction.
- im_ready  in  1  IM accepts the write this cycle.
- err_illegal  out  1  one-cycle pulse: illegal mnemonic dropped.
- err_range  out  1  one-cycle pulse: target misaligned or out of reach; request dropped.
- wr_count  out  COUNT_W  completed writes since reset or base_load; wraps.

Behaviour:
- Reset values: pc = RESET_PC; FSM = IDLE; in_ready = 1; im_we = 0; im_wdata = 0; im_addr = RESET_PC; err_* = 0; wr_count = 0.
- FSM states:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture all in_* fields and go to ENC. base_load in IDLE sets pc and clears wr_count; if it coincides with an accept, base_load wins and the request is not accepted (in_ready is 0 that cycle).
  - ENC: in_ready = 0. Build the word into a register.
    - Illegal mnemonic or range error: pulse the matching err_* for one cycle, return to IDLE, leave pc unchanged.
    - Otherwise go to WR.
  - WR: im_we = 1, im_addr = pc, im_wdata = encoded word. All three are held stable while im_ready = 0. On im_ready: pc += 4 (wraps at 2^32), wr_count += 1, go to IDLE.
- Latency: accept at cycle N, ENC at N+1, im_we first high at N+2; in_ready returns at N+3 if im_ready was high at N+2. Peak throughput is 1 word per 3 cycles.
- Encoding:
  - R-type: {6'h00, rs, rt, rd, shamt, funct}.
  - SLL/SRL/SRA: rs = 0.
  - SLLV/SRLV/SRAV: shamt = 0.
  - JR: {0, rs, 15'b0, 6'h08}.
  - I-type: {op, rs, rt, imm}. LUI forces rs = 0.
  - BEQ/BNE: off = (in_target − (pc+4)) >>> 2, 32-bit signed arithmetic. Word = {op, rs, rt, off[15:0]}. err_range if in_target[1:0] ≠ 0 or off is outside [−32768, 32767].
  - J/JAL: {op, in_target[27:2]}. err_range if in_target[1:0] ≠ 0 or in_target[31:28] ≠ (pc+4)[31:28].
- Fields not used by an op are masked to 0 in the emitted word.
- Asynchronous reset mid-WR drops im_we immediately and discards the pending word.
- in_valid while not ready is ignored; the requester must hold the request until in_ready.

Decomposition:
- Add to risc.v:
  - ENC_MN_* codes, 0..30 in the order ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, ADDI, ADDIU, ANDI, ORI, XORI, LUI, SLTI, SLTIU, LW, SW, BEQ, BNE, J, JAL; ENC_MN_ILLEGAL = 31.
  - FSM state defines.
- Reuse the existing INSTR_OP_* and INSTR_FUNCT_* defines.
- One combinational sub-module, mips_word_pack: mnemonic, fields, pc → word, illegal flag, range flag. The FSM, pointer and counter stay in the top module.

Test Plan:
- Reset with im_ready = 1; ADDI rt=8 rs=0 imm=0x0005 → im_wdata 0x20080005 at im_addr 0x3000 on the third cycle after accept; wr_count = 1.
- ADD rd=10 rs=8 rt=9 at 0x3004 → 0x01095020. Then SLL rd=2 rt=3 shamt=4 with rs=7 → 0x00031100 (rs masked).
- BEQ at pc 0x3008, rs=1 rt=2 target 0x3000 → 0x1022FFFD. Then J at 0x300C target 0x3000 → 0x08000C00. JAL → 0x0C000C00.
- Hold im_ready = 0 for 3 cycles during WR → im_we, im_addr and im_wdata stay stable and in_ready = 0; the write completes on the first im_ready = 1.
- in_mnem = 31 → err_illegal pulses for 1 cycle, no im_we, pc unchanged. BEQ target 0x3002 → err_range pulses, no write. BEQ target pc+4+0x20000 → err_range.
- Assert rst mid-WR → im_we = 0 in the same cycle, im_addr = 0x3000, wr_count = 0. base_load 0x4003 in IDLE → next write lands at 0x4000.

Source files
------------

// File: rtl/mips_instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder.
//   - enc_mn_e    : mnemonic codes accepted on in_mnem (31 is reserved as illegal)
//   - enc_state_e : encoder FSM states
//   - INSTR_OP_* / INSTR_FUNCT_* : primary opcodes and R-type function codes,
//     the same values the core's Ctrl/ALUCtrl decode path expects.
package mips_instr_encoder_pkg;

  typedef enum logic [4:0] {
    ENC_MN_ADD     = 5'd0,
    ENC_MN_ADDU    = 5'd1,
    ENC_MN_SUB     = 5'd2,
    ENC_MN_SUBU    = 5'd3,
    ENC_MN_AND     = 5'd4,
    ENC_MN_OR      = 5'd5,
    ENC_MN_XOR     = 5'd6,
    ENC_MN_NOR     = 5'd7,
    ENC_MN_SLT     = 5'd8,
    ENC_MN_SLTU    = 5'd9,
    ENC_MN_SLL     = 5'd10,
    ENC_MN_SRL     = 5'd11,
    ENC_MN_SRA     = 5'd12,
    ENC_MN_SLLV    = 5'd13,
    ENC_MN_SRLV    = 5'd14,
    ENC_MN_SRAV    = 5'd15,
    ENC_MN_JR      = 5'd16,
    ENC_MN_ADDI    = 5'd17,
    ENC_MN_ADDIU   = 5'd18,
    ENC_MN_ANDI    = 5'd19,
    ENC_MN_ORI     = 5'd20,
    ENC_MN_XORI    = 5'd21,
    ENC_MN_LUI     = 5'd22,
    ENC_MN_SLTI    = 5'd23,
    ENC_MN_SLTIU   = 5'd24,
    ENC_MN_LW      = 5'd25,
    ENC_MN_SW      = 5'd26,
    ENC_MN_BEQ     = 5'd27,
    ENC_MN_BNE     = 5'd28,
    ENC_MN_J       = 5'd29,
    ENC_MN_JAL     = 5'd30,
    ENC_MN_ILLEGAL = 5'd31
  } enc_mn_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_WR   = 2'd2
  } enc_state_e;

  localparam logic [5:0] INSTR_OP_RTYPE = 6'h00;
  localparam logic [5:0] INSTR_OP_J     = 6'h02;
  localparam logic [5:0] INSTR_OP_JAL   = 6'h03;
  localparam logic [5:0] INSTR_OP_BEQ   = 6'h04;
  localparam logic [5:0] INSTR_OP_BNE   = 6'h05;
  localparam logic [5:0] INSTR_OP_ADDI  = 6'h08;
  localparam logic [5:0] INSTR_OP_ADDIU = 6'h09;
  localparam logic [5:0] INSTR_OP_SLTI  = 6'h0A;
  localparam logic [5:0] INSTR_OP_SLTIU = 6'h0B;
  localparam logic [5:0] INSTR_OP_ANDI  = 6'h0C;
  localparam logic [5:0] INSTR_OP_ORI   = 6'h0D;
  localparam logic [5:0] INSTR_OP_XORI  = 6'h0E;
  localparam logic [5:0] INSTR_OP_LUI   = 6'h0F;
  localparam logic [5:0] INSTR_OP_LW    = 6'h23;
  localparam logic [5:0] INSTR_OP_SW    = 6'h2B;

  localparam logic [5:0] INSTR_FUNCT_SLL  = 6'h00;
  localparam logic [5:0] INSTR_FUNCT_SRL  = 6'h02;
  localparam logic [5:0] INSTR_FUNCT_SRA  = 6'h03;
  localparam logic [5:0] INSTR_FUNCT_SLLV = 6'h04;
  localparam logic [5:0] INSTR_FUNCT_SRLV = 6'h06;
  localparam logic [5:0] INSTR_FUNCT_SRAV = 6'h07;
  localparam logic [5:0] INSTR_FUNCT_JR   = 6'h08;
  localparam logic [5:0] INSTR_FUNCT_ADD  = 6'h20;
  localparam logic [5:0] INSTR_FUNCT_ADDU = 6'h21;
  localparam logic [5:0] INSTR_FUNCT_SUB  = 6'h22;
  localparam logic [5:0] INSTR_FUNCT_SUBU = 6'h23;
  localparam logic [5:0] INSTR_FUNCT_AND  = 6'h24;
  localparam logic [5:0] INSTR_FUNCT_OR   = 6'h25;
  localparam logic [5:0] INSTR_FUNCT_XOR  = 6'h26;
  localparam logic [5:0] INSTR_FUNCT_NOR  = 6'h27;
  localparam logic [5:0] INSTR_FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] INSTR_FUNCT_SLTU = 6'h2B;

endpackage

// File: rtl/mips_instr_encoder_pack.sv
// Combinational word packer: turns one mnemonic-level request into a 32-bit
// MIPS word. Fields an op does not use are forced to zero.
//   mnem, rs, rt, rd, shamt, imm, target : captured request fields
//   pc        : address the word will be written to (branch/jump base)
//   word      : encoded instruction
//   illegal   : mnemonic is not one the core decodes
//   range_err : branch/jump target misaligned or unreachable from pc
module mips_word_pack
  import mips_instr_encoder_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [31:0] target,
  input  logic [31:0] pc,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);

  function automatic logic [31:0] r_word(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                         input logic [4:0] f_rd, input logic [4:0] f_sh,
                                         input logic [5:0] funct);
    return {INSTR_OP_RTYPE, f_rs, f_rt, f_rd, f_sh, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] f_rs,
                                         input logic [4:0] f_rt, input logic [15:0] f_imm);
    return {op, f_rs, f_rt, f_imm};
  endfunction

  logic        [31:0] pc4;
  logic signed [31:0] diff;
  logic signed [31:0] off;
  logic               br_bad;
  logic               j_bad;

  always_comb begin
    pc4  = pc + 32'd4;
    diff = $signed(target) - $signed(pc4);
    off  = diff >>> 2;
    // Offset fits in 16 signed bits only if bits [31:15] are a pure sign extension.
    br_bad = (target[1:0] != 2'b00) || (off[31:15] != {17{off[15]}});
    // J/JAL can only reach the 256 MB region that holds the delay slot.
    j_bad  = (target[1:0] != 2'b00) || (target[31:28] != pc4[31:28]);
  end

  always_comb begin
    word      = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (mnem)
      ENC_MN_ADD:   word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_ADD);
      ENC_MN_ADDU:  word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_ADDU);
      ENC_MN_SUB:   word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_SUB);
      ENC_MN_SUBU:  word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_SUBU);
      ENC_MN_AND:   word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_AND);
      ENC_MN_OR:    word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_OR);
      ENC_MN_XOR:   word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_XOR);
      ENC_MN_NOR:   word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_NOR);
      ENC_MN_SLT:   word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_SLT);
      ENC_MN_SLTU:  word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_SLTU);
      ENC_MN_SLL:   word = r_word(5'd0, rt, rd, shamt, INSTR_FUNCT_SLL);
      ENC_MN_SRL:   word = r_word(5'd0, rt, rd, shamt, INSTR_FUNCT_SRL);
      ENC_MN_SRA:   word = r_word(5'd0, rt, rd, shamt, INSTR_FUNCT_SRA);
      ENC_MN_SLLV:  word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_SLLV);
      ENC_MN_SRLV:  word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_SRLV);
      ENC_MN_SRAV:  word = r_word(rs, rt, rd, 5'd0, INSTR_FUNCT_SRAV);
      ENC_MN_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, INSTR_FUNCT_JR);
      ENC_MN_ADDI:  word = i_word(INSTR_OP_ADDI, rs, rt, imm);
      ENC_MN_ADDIU: word = i_word(INSTR_OP_ADDIU, rs, rt, imm);
      ENC_MN_ANDI:  word = i_word(INSTR_OP_ANDI, rs, rt, imm);
      ENC_MN_ORI:   word = i_word(INSTR_OP_ORI, rs, rt, imm);
      ENC_MN_XORI:  word = i_word(INSTR_OP_XORI, rs, rt, imm);
      ENC_MN_LUI:   word = i_word(INSTR_OP_LUI, 5'd0, rt, imm);
      ENC_MN_SLTI:  word = i_word(INSTR_OP_SLTI, rs, rt, imm);
      ENC_MN_SLTIU: word = i_word(INSTR_OP_SLTIU, rs, rt, imm);
      ENC_MN_LW:    word = i_word(INSTR_OP_LW, rs, rt, imm);
      ENC_MN_SW:    word = i_word(INSTR_OP_SW, rs, rt, imm);
      ENC_MN_BEQ: begin
        word      = i_word(INSTR_OP_BEQ, rs, rt, off[15:0]);
        range_err = br_bad;
      end
      ENC_MN_BNE: begin
        word      = i_word(INSTR_OP_BNE, rs, rt, off[15:0]);
        range_err = br_bad;
      end
      ENC_MN_J: begin
        word      = {INSTR_OP_J, target[27:2]};
        range_err = j_bad;
      end
      ENC_MN_JAL: begin
        word      = {INSTR_OP_JAL, target[27:2]};
        range_err = j_bad;
      end
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts mnemonic-level requests, encodes them into MIPS
// words and writes them sequentially into instruction memory.
//   clk, rst              : clock, asynchronous active-high reset
//   base_load, base_addr  : reposition the write pointer (IDLE only)
//   in_valid/in_ready, in_* : request handshake and fields
//   im_we/im_addr/im_wdata/im_ready : IM write port, held until im_ready
//   err_illegal, err_range : one-cycle pulses for dropped requests
//   wr_count              : completed writes since reset or base_load
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               base_load,
  input  logic [31:0]        base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_mnem,
  input  logic [4:0]         in_rs,
  input  logic [4:0]         in_rt,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_shamt,
  input  logic [15:0]        in_imm,
  input  logic [31:0]        in_target,
  output logic               im_we,
  output logic [31:0]        im_addr,
  output logic [31:0]        im_wdata,
  input  logic               im_ready,
  output logic               err_illegal,
  output logic               err_range,
  output logic [COUNT_W-1:0] wr_count
);

  enc_state_e  state;
  logic        rdy;
  logic [31:0] pc;
  logic        accept;

  logic [4:0]  mnem_p1, rs_p1, rt_p1, rd_p1, shamt_p1;
  logic [15:0] imm_p1;
  logic [31:0] target_p1;

  logic [31:0] pk_word;
  logic        pk_illegal;
  logic        pk_range;

  // base_load takes priority over a coincident request, so it masks ready.
  assign in_ready = rdy & ~base_load;
  assign accept   = in_valid & in_ready;

  // ---- Capture stage: request fields latched on accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      mnem_p1   <= in_mnem;
      rs_p1     <= in_rs;
      rt_p1     <= in_rt;
      rd_p1     <= in_rd;
      shamt_p1  <= in_shamt;
      imm_p1    <= in_imm;
      target_p1 <= in_target;
    end
  end

  mips_word_pack u_pack (
    .mnem      (mnem_p1),
    .rs        (rs_p1),
    .rt        (rt_p1),
    .rd        (rd_p1),
    .shamt     (shamt_p1),
    .imm       (imm_p1),
    .target    (target_p1),
    .pc        (pc),
    .word      (pk_word),
    .illegal   (pk_illegal),
    .range_err (pk_range)
  );

  // ---- Encode/write stage: FSM, pointer and counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rdy         <= 1'b1;
      pc          <= RESET_PC;
      im_we       <= 1'b0;
      im_addr     <= RESET_PC;
      im_wdata    <= '0;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
      wr_count    <= '0;
    end else begin
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (base_load) begin
            pc       <= base_addr & 32'hFFFF_FFFC;
            wr_count <= '0;
          end else if (in_valid) begin
            state <= ST_ENC;
            rdy   <= 1'b0;
          end
        end
        ST_ENC: begin
          if (pk_illegal || pk_range) begin
            err_illegal <= pk_illegal;
            err_range   <= pk_range & ~pk_illegal;
            state       <= ST_IDLE;
            rdy         <= 1'b1;
          end else begin
            im_we    <= 1'b1;
            im_addr  <= pc;
            im_wdata <= pk_word;
            state    <= ST_WR;
          end
        end
        ST_WR: begin
          if (im_ready) begin
            im_we    <= 1'b0;
            pc       <= pc + 32'd4;
            wr_count <= wr_count + COUNT_W'(1);
            state    <= ST_IDLE;
            rdy      <= 1'b1;
          end
        end
        default: begin
          im_we <= 1'b0;
          state <= ST_IDLE;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule
